// File: rtl/vc_mem_arb.sv
// rtl/vc_mem_arb.sv - shares the external line-fill/writeback port between the I and D cache engines
// One grant covers a whole line burst; a starvation counter bounds how long D can hold off I.
module vc_mem_arb #(
  parameter int PA         = 24,
  parameter int DW         = 16,
  parameter int LINE_BEATS = 4,
  parameter int STARVE     = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [PA-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic          i_done,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [PA-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic          d_wready,
  output logic          d_done,
  output logic [DW-1:0] rdata,
  output logic          m_req,
  output logic          m_wr,
  output logic [PA-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_valid
);

  localparam int BW  = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam int OFS = $clog2(LINE_BEATS * DW / 8);
  localparam int SW  = (STARVE > 0) ? $clog2(STARVE + 1) : 1;

  localparam logic [PA-1:0] LINE_MASK = {PA{1'b1}} << OFS;
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_BEATS - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          owner_d;
  logic          wr_q;
  logic [PA-1:0] addr_q;
  logic [BW-1:0] beat;
  logic [SW-1:0] starve_cnt;

  logic          xfer;
  logic          arb;
  logic          d_win;
  logic          last;
  logic [PA-1:0] win_addr;

  assign xfer     = (state == XFER);
  assign arb      = (state == IDLE) && (i_req || d_req);
  // D wins a contended slot unless I has already been passed over STARVE times
  assign d_win    = d_req && (!i_req || (starve_cnt != STARVE_MAX));
  assign win_addr = (d_win ? d_addr : i_addr) & LINE_MASK;
  assign last     = xfer && m_valid && (beat == LAST_BEAT);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_req || d_req) state_nxt = XFER;
      XFER:    if (last) state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner_d    <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      beat       <= '0;
      starve_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (arb) begin
        owner_d <= d_win;
        wr_q    <= d_win && d_wr;
        addr_q  <= win_addr;
        beat    <= '0;
        if (d_win && i_req) begin
          if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + SW'(1);
        end else begin
          starve_cnt <= '0;
        end
      end else if (xfer && m_valid) begin
        beat <= beat + BW'(1);
      end
    end
  end

  // Strobes are the only paths from m_valid; everything else comes from registered state
  assign m_req    = xfer;
  assign m_wr     = wr_q;
  assign m_addr   = addr_q;
  assign i_gnt    = xfer && !owner_d;
  assign d_gnt    = xfer && owner_d;
  assign i_rvalid = i_gnt && m_valid;
  assign d_rvalid = d_gnt && !wr_q && m_valid;
  assign d_wready = d_gnt && wr_q && m_valid;
  assign i_done   = i_gnt && last;
  assign d_done   = d_gnt && last;
  assign rdata    = (xfer && !wr_q) ? m_rdata : '0;
  assign m_wdata  = (d_gnt && wr_q) ? d_wdata : '0;

endmodule

// File: tb/tb_vc_mem_arb.sv
// tb/tb_vc_mem_arb.sv - directed-vector bench for vc_mem_arb
module tb_vc_mem_arb;

  localparam int PA = 24;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req;
  logic [PA-1:0] i_addr;
  logic          i_gnt, i_rvalid, i_done;
  logic          d_req, d_wr;
  logic [PA-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt, d_rvalid, d_wready, d_done;
  logic [DW-1:0] rdata;
  logic          m_req, m_wr;
  logic [PA-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          m_valid;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vc_mem_arb #(.PA(PA), .DW(DW), .LINE_BEATS(4), .STARVE(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_done(i_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_wready(d_wready), .d_done(d_done),
    .rdata(rdata), .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_valid(m_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  logic [6:0] stall_pat;
  logic       exp_d [6];
  int         nv;
  int         t;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; i_req = 0; i_addr = '0; d_req = 0; d_wr = 0; d_addr = '0;
    d_wdata = '0; m_rdata = '0; m_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    m_valid = 1; m_rdata = 16'hBEEF;
    #1;
    chk("rst_m_req", m_req, 0);
    chk("rst_gnt", {i_gnt, d_gnt}, 0);
    chk("rst_strobes", {i_rvalid, i_done, d_rvalid, d_wready, d_done}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_m_addr", m_addr, 0);
    m_valid = 0;
    rst_n = 1'b1;

    // D write, reset asserted after two beats
    d_req = 1; d_wr = 1; d_addr = 24'h000100; d_wdata = 16'h1111;
    #1;
    chk("pre_grant_m_req", m_req, 0);
    step;
    m_valid = 1;
    #1;
    chk("rstb_d_gnt", d_gnt, 1);
    chk("rstb_wready0", d_wready, 1);
    chk("rstb_wdata", m_wdata, 16'h1111);
    step;
    #1;
    chk("rstb_wready1", d_wready, 1);
    step;
    rst_n = 1'b0;
    #1;
    chk("rstb_async_m_req", m_req, 0);
    chk("rstb_async_gnt", d_gnt, 0);
    chk("rstb_async_strb", {d_wready, d_done}, 0);
    chk("rstb_async_addr", m_addr, 0);
    chk("rstb_async_wr", m_wr, 0);
    chk("rstb_async_wdata", m_wdata, 0);
    step;
    rst_n = 1'b1; d_req = 0; d_wr = 0;
    #1;
    chk("stray_idle_strb", {d_wready, d_done, d_rvalid, i_rvalid, i_done}, 0);
    step;
    chk("stray_idle_m_req", m_req, 0);
    m_valid = 0;

    // Single I fill
    i_req = 1; i_addr = 24'h12345F;
    step;
    i_addr = 24'hFFFFFF;
    for (int b = 0; b < 4; b++) begin
      m_valid = 1; m_rdata = 16'h00A0 + 16'(b);
      #1;
      chk("ifill_gnt", {i_gnt, d_gnt}, 2'b10);
      chk("ifill_m_addr", m_addr, 24'h123458);
      chk("ifill_m_wr", m_wr, 0);
      chk("ifill_rvalid", i_rvalid, 1);
      chk("ifill_rdata", rdata, 16'h00A0 + 16'(b));
      chk("ifill_done", i_done, (b == 3) ? 1 : 0);
      chk("ifill_d_strb", {d_rvalid, d_done}, 0);
      step;
    end
    i_req = 0; m_valid = 0;
    #1;
    chk("ifill_gap_m_req", m_req, 0);
    step;
    chk("ifill_idle_m_req", m_req, 0);

    // D writeback with stalls
    stall_pat = 7'b1011001;
    d_req = 1; d_wr = 1; d_addr = 24'h000ABC;
    step;
    nv = 0;
    for (int j = 0; j < 7; j++) begin
      m_valid = stall_pat[j];
      d_wdata = 16'hD000 + 16'(j);
      #1;
      chk("dwb_gnt", {i_gnt, d_gnt}, 2'b01);
      chk("dwb_m_addr", m_addr, 24'h000AB8);
      chk("dwb_m_wr", m_wr, 1);
      chk("dwb_wready", d_wready, stall_pat[j]);
      chk("dwb_wdata", m_wdata, 16'hD000 + 16'(j));
      chk("dwb_done", d_done, (stall_pat[j] && nv == 3) ? 1 : 0);
      chk("dwb_i_strb", {i_rvalid, i_done, d_rvalid}, 0);
      if (stall_pat[j]) nv++;
      step;
    end
    d_req = 0; d_wr = 0; m_valid = 0;
    #1;
    chk("dwb_gap", m_req, 0);
    step;

    // Held request after done, stray m_valid in GAP and IDLE
    d_req = 1; d_addr = 24'h000200;
    step;
    for (int b = 0; b < 4; b++) begin
      m_valid = 1;
      #1;
      chk("held_rvalid", d_rvalid, 1);
      chk("held_done", d_done, (b == 3) ? 1 : 0);
      step;
    end
    d_addr = 24'h00031F;
    #1;
    chk("held_gap_m_req", m_req, 0);
    chk("held_gap_strb", {d_gnt, d_rvalid, d_done, d_wready}, 0);
    step;
    #1;
    chk("held_idle_m_req", m_req, 0);
    chk("held_idle_strb", {d_rvalid, d_done}, 0);
    step;
    m_valid = 0;
    #1;
    chk("held_regrant", d_gnt, 1);
    chk("held_new_addr", m_addr, 24'h000318);
    nv = 0;
    for (int j = 0; j < 6; j++) begin
      m_valid = (j != 1 && j != 3);
      #1;
      chk("held_b2_done", d_done, (m_valid && nv == 3) ? 1 : 0);
      if (m_valid) nv++;
      step;
    end
    d_req = 0; m_valid = 0;
    step;
    step;

    // Contention: grant order D, D, I, D, D, I
    exp_d[0] = 1; exp_d[1] = 1; exp_d[2] = 0; exp_d[3] = 1; exp_d[4] = 1; exp_d[5] = 0;
    i_req = 1; d_req = 1; d_wr = 0; i_addr = 24'h001000; d_addr = 24'h002000; m_valid = 1;
    for (int g = 0; g < 6; g++) begin
      t = 0;
      while (!m_req && t < 10) begin
        step;
        t++;
      end
      chk("cont_grant_seen", m_req, 1);
      chk("cont_owner", {i_gnt, d_gnt}, exp_d[g] ? 2'b01 : 2'b10);
      chk("cont_starve_le2", (dut.starve_cnt <= 2) ? 1 : 0, 1);
      for (int b = 0; b < 3; b++) step;
      #1;
      chk("cont_done", {i_done, d_done}, exp_d[g] ? 2'b01 : 2'b10);
      step;
    end
    i_req = 0; d_req = 0; m_valid = 0;
    step;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
